qed_consistency_checker: RTL

- Commit-side counterpart of the QED instruction-duplication front end: consumes the retire stream the front end produces, and checks the architectural consistency it is meant to preserve.
- Counts retired original and duplicate instructions.
- When the counts match and a check is requested, it scans each original/duplicate register pair (x1..x15 vs x16+i) through a register-file read port and reports pass/fail.
- Sits between the core's retire interface and the formal bench's top-level assertion.

---
 rtl/qed_consistency_checker_pkg.sv | 19 +
 rtl/qed_consistency_checker_retire_counter.sv | 43 ++++
 rtl/qed_consistency_checker.sv | 134 +++++++++++++
 3 files changed

// File: rtl/qed_consistency_checker_pkg.sv
// Shared QED definitions used by the front end, this checker and the formal top.
// Holds the scan FSM state encoding, the original-to-duplicate register offset
// and the default sizing constants.
package qed_consistency_checker_pkg;

  // Duplicate of architectural register xi lives in x(i+16).
  localparam int DUP_REG_OFFSET = 16;
  localparam int NUM_PAIRS_DEF  = 15;
  localparam int CNT_W_DEF      = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_ORIG,
    ST_RD_DUP,
    ST_CMP,
    ST_DONE
  } scan_state_e;

endpackage

// File: rtl/qed_consistency_checker_retire_counter.sv
// qed_retire_counter: saturating counts of retired original and duplicate
// instructions, plus the derived qed_ready and sticky dup_overrun flags.
// Ports:
//   clk, resetn                 clock, synchronous active-low reset
//   retire_valid, retire_is_dup retire strobe and its original/duplicate tag
//   num_orig, num_dup           retire counters, saturating at all-ones
//   qed_ready                   counts equal and nonzero (combinational)
//   dup_overrun                 sticky: a duplicate retired with num_dup >= num_orig
module qed_retire_counter
  import qed_consistency_checker_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             retire_valid,
  input  logic             retire_is_dup,
  output logic [CNT_W-1:0] num_orig,
  output logic [CNT_W-1:0] num_dup,
  output logic             qed_ready,
  output logic             dup_overrun
);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      num_orig    <= '0;
      num_dup     <= '0;
      dup_overrun <= 1'b0;
    end else if (retire_valid) begin
      if (!retire_is_dup) begin
        if (num_orig != '1) num_orig <= num_orig + CNT_W'(1);
      end else begin
        if (num_dup != '1) num_dup <= num_dup + CNT_W'(1);
        // Compared against pre-increment values: a duplicate with no
        // outstanding original to shadow.
        if (num_dup >= num_orig) dup_overrun <= 1'b1;
      end
    end
  end

  assign qed_ready = (num_orig == num_dup) && (num_orig != '0);

endmodule

// File: rtl/qed_consistency_checker.sv
// qed_consistency_checker: counts the QED retire stream and, on request, scans
// register pairs xi / x(i+16) for i = 1..NUM_PAIRS through a one-cycle-latency
// register-file read port, reporting pass/fail and the lowest failing pair.
// Ports:
//   clk, resetn                 clock, synchronous active-low reset
//   retire_valid, retire_is_dup retire stream from the core
//   check_start                 scan request, accepted only when idle, qed_ready, no retire
//   rf_raddr / rf_rdata         register-file read port (data one cycle after address)
//   num_orig, num_dup           retire counters
//   qed_ready, dup_overrun      counter status
//   check_busy, check_done      scan in progress / one-cycle completion pulse
//   check_pass, mismatch_idx    result of the last completed scan
//
// state      | meaning
// -----------+-----------------------------------------------
// ST_IDLE    | waiting for an accepted check_start
// ST_RD_ORIG | address original register xi
// ST_RD_DUP  | capture xi, address duplicate x(i+16)
// ST_CMP     | compare x(i+16) with captured xi, advance i
// ST_DONE    | publish result, pulse check_done
module qed_consistency_checker
  import qed_consistency_checker_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int CNT_W     = CNT_W_DEF,
  parameter int NUM_PAIRS = NUM_PAIRS_DEF
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             retire_valid,
  input  logic             retire_is_dup,
  input  logic             check_start,
  output logic [4:0]       rf_raddr,
  input  logic [XLEN-1:0]  rf_rdata,
  output logic [CNT_W-1:0] num_orig,
  output logic [CNT_W-1:0] num_dup,
  output logic             qed_ready,
  output logic             dup_overrun,
  output logic             check_busy,
  output logic             check_done,
  output logic             check_pass,
  output logic [3:0]       mismatch_idx
);

  scan_state_e     state, state_nx;
  logic [3:0]      idx;
  logic [XLEN-1:0] orig_q;
  logic            fail;
  logic [3:0]      fail_idx;

  qed_retire_counter #(.CNT_W(CNT_W)) u_cnt (
    .clk           (clk),
    .resetn        (resetn),
    .retire_valid  (retire_valid),
    .retire_is_dup (retire_is_dup),
    .num_orig      (num_orig),
    .num_dup       (num_dup),
    .qed_ready     (qed_ready),
    .dup_overrun   (dup_overrun)
  );

  always_ff @(posedge clk) begin
    if (!resetn) state <= ST_IDLE;
    else         state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    rf_raddr = '0;
    case (state)
      ST_IDLE: begin
        if (check_start && qed_ready && !retire_valid) state_nx = ST_RD_ORIG;
      end
      ST_RD_ORIG: begin
        rf_raddr = {1'b0, idx};
        state_nx = ST_RD_DUP;
      end
      ST_RD_DUP: begin
        rf_raddr = {1'b0, idx} + 5'(DUP_REG_OFFSET);
        state_nx = ST_CMP;
      end
      ST_CMP: begin
        state_nx = (idx < 4'(NUM_PAIRS)) ? ST_RD_ORIG : ST_DONE;
      end
      ST_DONE: state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
    // A retire changes architectural state under the scan, so abandon it.
    if (state != ST_IDLE && retire_valid) state_nx = ST_IDLE;
  end

  assign check_busy = (state != ST_IDLE);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      idx          <= '0;
      orig_q       <= '0;
      fail         <= 1'b0;
      fail_idx     <= '0;
      check_done   <= 1'b0;
      check_pass   <= 1'b0;
      mismatch_idx <= '0;
    end else begin
      check_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (state_nx == ST_RD_ORIG) begin
            idx      <= 4'd1;
            fail     <= 1'b0;
            fail_idx <= '0;
          end
        end
        ST_RD_DUP: orig_q <= rf_rdata;
        ST_CMP: begin
          // Keep only the first (lowest) failing pair.
          if (rf_rdata != orig_q && !fail) begin
            fail     <= 1'b1;
            fail_idx <= idx;
          end
          idx <= idx + 4'd1;
        end
        ST_DONE: begin
          if (!retire_valid) begin
            check_done   <= 1'b1;
            check_pass   <= !fail;
            mismatch_idx <= fail ? fail_idx : 4'd0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
